frame_filter_stage: RTL and testbench

FRAME_FILTER_STAGE -- requirements
Module: frame_filter_stage

---
 rtl/frame_filter_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_frame_filter_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_filter_stage.sv
// frame_filter_stage: byte-wide Avalon-ST destination-MAC filter with an
// Avalon-MM control/status slave.
// Optional build macro FRAME_FILTER_STATS_EN: builds the saturating pass/drop
// frame counters; without it, counter addresses read as zero.
module frame_filter_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  // ingress
  input  logic [7:0]  sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  // egress
  output logic [7:0]  src_data,
  output logic        src_valid,
  output logic        src_sop,
  output logic        src_eop,
  input  logic        src_ready,
  // control/status
  input  logic [1:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata
);

  typedef enum logic [2:0] {IDLE, HDR, FLUSH, PASS, DROP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_q [6];
  logic [2:0]  idx_q;
  logic [2:0]  idx_nx;
  logic        last_eop_q;
  logic [7:0]  src_data_q;
  logic        src_valid_q, src_sop_q, src_eop_q;
  logic [47:0] mac_q;
  logic        en_q;

  logic        hdr_restart, hdr_wr, decide, flush_adv, flush_done;
  logic        pass_inc, drop_inc;
  logic [47:0] dest_mac;
  logic        mac_hit;
  logic [31:0] rd_mux, pass_word, drop_word;

  assign idx_nx   = idx_q + 3'd1;
  // Byte 5 is still on the sink bus when the decision is made.
  assign dest_mac = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], sink_data};
  assign mac_hit  = !en_q || (dest_mac == mac_q) || (dest_mac == '1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, handshake and egress muxing; PASS bypasses the output registers.
  always_comb begin
    state_d     = state_q;
    sink_ready  = 1'b0;
    src_data    = src_data_q;
    src_valid   = src_valid_q;
    src_sop     = src_sop_q;
    src_eop     = src_eop_q;
    hdr_restart = 1'b0;
    hdr_wr      = 1'b0;
    decide      = 1'b0;
    flush_adv   = 1'b0;
    flush_done  = 1'b0;
    pass_inc    = 1'b0;
    drop_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sink_ready = 1'b1;
        if (sink_valid && sink_sop) begin
          if (sink_eop) begin
            drop_inc = 1'b1;
          end else begin
            hdr_restart = 1'b1;
            state_d     = HDR;
          end
        end
      end
      HDR: begin
        sink_ready = 1'b1;
        if (sink_valid) begin
          if (sink_sop) begin
            if (sink_eop) begin
              drop_inc = 1'b1;
              state_d  = IDLE;
            end else begin
              hdr_restart = 1'b1;
            end
          end else if (idx_q == 3'd5) begin
            if (mac_hit) begin
              decide  = 1'b1;
              state_d = FLUSH;
            end else begin
              drop_inc = 1'b1;
              // A rejected frame that already ended has nothing left to skip.
              state_d  = sink_eop ? IDLE : DROP;
            end
          end else if (sink_eop) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            hdr_wr = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (src_valid_q && src_ready) begin
          if (idx_q == 3'd5) begin
            flush_done = 1'b1;
            if (last_eop_q) begin
              pass_inc = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = PASS;
            end
          end else begin
            flush_adv = 1'b1;
          end
        end
      end
      PASS: begin
        sink_ready = src_ready;
        src_data   = sink_data;
        src_valid  = sink_valid;
        src_sop    = 1'b0;
        src_eop    = sink_eop;
        if (sink_valid && src_ready && sink_eop) begin
          pass_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      DROP: begin
        sink_ready = 1'b1;
        if (sink_valid && sink_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Header capture and registered replay of the buffered header bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 6; i++) hdr_q[i] <= '0;
      idx_q       <= '0;
      last_eop_q  <= 1'b0;
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
    end else if (decide) begin
      hdr_q[5]    <= sink_data;
      idx_q       <= '0;
      last_eop_q  <= sink_eop;
      src_data_q  <= hdr_q[0];
      src_valid_q <= 1'b1;
      src_sop_q   <= 1'b1;
      src_eop_q   <= 1'b0;
    end else if (flush_adv) begin
      idx_q      <= idx_nx;
      src_data_q <= hdr_q[idx_nx];
      src_sop_q  <= 1'b0;
      src_eop_q  <= last_eop_q && (idx_q == 3'd4);
    end else if (flush_done) begin
      idx_q       <= '0;
      src_valid_q <= 1'b0;
      src_eop_q   <= 1'b0;
    end else if (hdr_restart) begin
      hdr_q[0] <= sink_data;
      idx_q    <= 3'd1;
    end else if (hdr_wr) begin
      hdr_q[idx_q] <= sink_data;
      idx_q        <= idx_nx;
    end else if (state_d == IDLE || state_d == DROP) begin
      idx_q <= '0;
    end
  end

`ifdef FRAME_FILTER_STATS_EN
  logic [CNT_W-1:0] pass_cnt, drop_cnt;
  logic             pass_clr, drop_clr;

  assign pass_clr = csr_write && (csr_address == 2'd2);
  assign drop_clr = csr_write && (csr_address == 2'd3);

  // Saturating frame counters; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_clr)                         pass_cnt <= '0;
      else if (pass_inc && pass_cnt != '1)  pass_cnt <= pass_cnt + CNT_W'(1);
      if (drop_clr)                         drop_cnt <= '0;
      else if (drop_inc && drop_cnt != '1)  drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign pass_word = 32'(pass_cnt);
  assign drop_word = 32'(drop_cnt);
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, pass_inc, drop_inc, CNT_W[0]};
  assign pass_word    = '0;
  assign drop_word    = '0;
`endif

  logic unused_wd;
  assign unused_wd = &{1'b0, csr_writedata[31:17]};

  // Read-data selection.
  always_comb begin
    rd_mux = '0;
    unique case (csr_address)
      2'd0:    rd_mux = mac_q[31:0];
      2'd1:    rd_mux = {15'd0, en_q, mac_q[47:32]};
      2'd2:    rd_mux = pass_word;
      default: rd_mux = drop_word;
    endcase
  end

  // Configuration registers and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_q        <= '0;
      en_q         <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (csr_write) begin
        unique case (csr_address)
          2'd0: mac_q[31:0] <= csr_writedata;
          2'd1: begin
            mac_q[47:32] <= csr_writedata[15:0];
            en_q         <= csr_writedata[16];
          end
          default: ;
        endcase
      end
      if (csr_read) csr_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_frame_filter_stage.sv
// Bench for frame_filter_stage: directed scenarios plus randomized frames,
// checked against a frame-level reference model (pass/drop decision per
// frame, expected egress byte queue, saturating counters).
module tb_frame_filter_stage;

  localparam int unsigned CW   = 3;
  localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef FRAME_FILTER_STATS_EN
  localparam logic [31:0] STATS_MASK = '1;
`else
  localparam logic [31:0] STATS_MASK = '0;
`endif
  localparam logic [47:0] MAC_A = 48'h0011_2233_4455;

  logic        clk, reset_n;
  logic [7:0]  sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [7:0]  src_data;
  logic        src_valid, src_sop, src_eop, src_ready;
  logic [1:0]  csr_address;
  logic        csr_write, csr_read;
  logic [31:0] csr_writedata, csr_readdata;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    int         pos;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [47:0] m_mac;
  logic        m_en;
  int unsigned m_pass, m_drop;
  logic [7:0]  fb [256];
  bit          fs [256];
  int          rdy_mode = 0;
  bit          gaps = 0;

  frame_filter_stage #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_ready   (sink_ready),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .src_ready    (src_ready),
    .csr_address  (csr_address),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned sat(input int unsigned c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Egress backpressure pattern.
  initial begin
    src_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = ~src_ready;
        default: src_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Egress monitor: every transferred beat must be the next expected byte,
  // and the sink must be stalled while buffered header bytes are replayed.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n) begin
        if (src_valid && exp_q.size() != 0 && exp_q[0].pos < 6)
          chk("flush_sink_ready", 32'(sink_ready), 32'd0);
        if (src_valid && src_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL egress_extra observed=%0h expected=none", src_data);
          end else begin
            b = exp_q.pop_front();
            chk($sformatf("egress_beat_pos%0d", b.pos),
                32'({src_sop, src_eop, src_data}), 32'({b.s, b.e, b.d}));
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int unsigned n = 0;
    bit done = 0;
    if (gaps && $urandom_range(3) == 0) @(negedge clk);
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = e;
    sink_valid = 1'b1;
    while (!done) begin
      #4;
      if (sink_ready) done = 1;
      else if (++n > 200) begin
        checks++;
        errors++;
        $error("FAIL sink_timeout observed=stalled expected=accept");
        done = 1;
      end
      @(negedge clk);
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic pulse_reset();
    sink_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("reset_src_valid", 32'(src_valid), 32'd0);
    chk("reset_src_sop", 32'(src_sop), 32'd0);
    chk("reset_src_eop", 32'(src_eop), 32'd0);
    chk("reset_egress_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_mac  = '0;
    m_en   = 1'b0;
    m_pass = 0;
    m_drop = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic make_frame(input logic [47:0] dest, input int len, input bit sop_rand);
    for (int i = 0; i < 6; i++) fb[i] = dest[47-8*i -: 8];
    for (int i = 6; i < len; i++) begin
      fb[i] = 8'($urandom);
      fs[i] = sop_rand && ($urandom_range(7) == 0);
    end
  endtask

  // Sends fb[0..len-1]; a non-negative reset_at pulses reset before that byte.
  task automatic send_frame(input int len, input int reset_at);
    logic [47:0] dest;
    bit pass;
    beat_t b;
    dest = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    pass = (len >= 6) && (!m_en || dest == m_mac || dest == '1);
    if (pass) begin
      for (int i = 0; i < len; i++) begin
        if (reset_at < 0 || i < reset_at) begin
          b.d = fb[i]; b.s = (i == 0); b.e = (i == len - 1); b.pos = i;
          exp_q.push_back(b);
        end
      end
    end
    for (int i = 0; i < len; i++) begin
      if (i == reset_at) pulse_reset();
      send_beat(fb[i], (i == 0 && reset_at != 0) || (i >= 6 && fs[i]), i == len - 1);
    end
    if (reset_at < 0) begin
      if (pass) m_pass = sat(m_pass);
      else      m_drop = sat(m_drop);
    end
    drain();
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] expv, input string tag);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    #1 chk(tag, csr_readdata, expv);
    @(negedge clk);
    #1 chk({tag, "_hold"}, csr_readdata, expv);
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [47:0] mac, input logic en);
    csr_wr(2'd0, mac[31:0]);
    csr_wr(2'd1, {15'd0, en, mac[47:32]});
    m_mac = mac;
    m_en  = en;
  endtask

  task automatic check_counts();
    csr_rd(2'd2, 32'(m_pass) & STATS_MASK, "pass_cnt");
    csr_rd(2'd3, 32'(m_drop) & STATS_MASK, "drop_cnt");
  endtask

  task automatic clear_counts();
    csr_wr(2'd2, 32'd0);
    csr_wr(2'd3, 32'd0);
    m_pass = 0;
    m_drop = 0;
  endtask

  initial begin
    logic [47:0] d;
    int len;
    reset_n = 1'b0;
    sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    csr_address = '0; csr_write = 1'b0; csr_read = 1'b0; csr_writedata = '0;
    m_mac = '0; m_en = 1'b0; m_pass = 0; m_drop = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_src_valid", 32'(src_valid), 32'd0);
    chk("rst_src_sop", 32'(src_sop), 32'd0);
    chk("rst_src_eop", 32'(src_eop), 32'd0);
    chk("rst_csr_readdata", csr_readdata, 32'd0);
    chk("rst_sink_ready", 32'(sink_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    csr_rd(2'd0, 32'd0, "rst_mac_lo");
    csr_rd(2'd1, 32'd0, "rst_mac_hi");
    check_counts();

    // Filter disabled: 64-byte frame passes untouched.
    make_frame(48'h1234_5678_9ABC, 64, 0);
    send_frame(64, -1);
    check_counts();

    // Programmed MAC, broadcast, and a near miss.
    set_cfg(MAC_A, 1'b1);
    csr_rd(2'd0, 32'h2233_4455, "mac_lo_rb");
    csr_rd(2'd1, 32'h0001_0011, "mac_hi_rb");
    clear_counts();
    make_frame(MAC_A, 16, 0);               send_frame(16, -1);
    make_frame(48'hFFFF_FFFF_FFFF, 16, 0);  send_frame(16, -1);
    make_frame(48'h0011_2233_4456, 16, 0);  send_frame(16, -1);
    check_counts();

    // Short frame then a normal one; 6-byte frames ending on the decision byte.
    make_frame(MAC_A, 4, 0);                send_frame(4, -1);
    make_frame(MAC_A, 10, 0);               send_frame(10, -1);
    make_frame(MAC_A, 6, 0);                send_frame(6, -1);
    make_frame(48'h0011_2233_4400, 6, 0);   send_frame(6, -1);
    make_frame(48'hFFFF_FFFF_FFFF, 7, 0);   send_frame(7, -1);
    check_counts();

    // Toggling egress backpressure on a 20-byte passing frame.
    rdy_mode = 1;
    make_frame(MAC_A, 20, 0);
    send_frame(20, -1);
    rdy_mode = 0;

    // Stray beats without sop, then a restarted header collection.
    send_beat(8'h00, 1'b0, 1'b0);
    send_beat(8'h11, 1'b0, 1'b1);
    send_beat(8'hAA, 1'b1, 1'b0);
    send_beat(8'hBB, 1'b0, 1'b0);
    make_frame(MAC_A, 12, 1);
    send_frame(12, -1);
    check_counts();

    // Randomized frames, lengths, gaps, backpressure and filter setting.
    gaps = 1;
    for (int f = 0; f < 30; f++) begin
      if (f % 6 == 0) set_cfg(MAC_A, 1'($urandom_range(1)));
      rdy_mode = int'($urandom_range(2));
      case ($urandom_range(3))
        0:       d = MAC_A;
        1:       d = 48'hFFFF_FFFF_FFFF;
        2:       d = MAC_A ^ (48'd1 << $urandom_range(47));
        default: d = 48'({$urandom(), $urandom()});
      endcase
      len = int'($urandom_range(1, 40));
      make_frame(d, len, 1);
      send_frame(len, -1);
    end
    gaps = 0;
    rdy_mode = 0;
    check_counts();

    // Drop counter saturation.
    clear_counts();
    for (int f = 0; f < 9; f++) begin
      len = int'($urandom_range(1, 5));
      make_frame(MAC_A, len, 0);
      send_frame(len, -1);
    end
    check_counts();

    // Clearing the pass counter at 5.
    clear_counts();
    for (int f = 0; f < 5; f++) begin
      make_frame(MAC_A, 8, 0);
      send_frame(8, -1);
    end
    csr_rd(2'd2, 32'd5 & STATS_MASK, "pass_cnt_at5");
    csr_wr(2'd2, 32'd0);
    m_pass = 0;
    csr_rd(2'd2, 32'd0, "pass_cnt_cleared");

    // Reset in the middle of a passing frame; remainder must be discarded.
    make_frame(MAC_A, 20, 0);
    send_frame(20, 10);
    csr_rd(2'd0, 32'd0, "mac_lo_after_reset");
    csr_rd(2'd1, 32'd0, "mac_hi_after_reset");
    check_counts();
    make_frame(48'h0A0B_0C0D_0E0F, 12, 0);
    send_frame(12, -1);
    check_counts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
